i2c_temp_sensor_responder: RTL and testbench

I2C target (responder) that emulates a two-byte temperature sensor on the bus driven by the team's I2C read-temperature controller. It detects START/STOP, matches a 7-bit address, ACKs read requests and returns a 16-bit temperature MSB-first. It is used as the bus-side model in system benches and as an on-FPGA sensor stand-in.

---
 rtl/i2c_temp_sensor_responder.sv | 163 ++++++++++++++++
 tb/tb_i2c_temp_sensor_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_temp_sensor_responder.sv
// I2C target emulating a two-byte temperature sensor: matches a 7-bit address on a
// read request and returns a 16-bit temperature MSB-first, open-drain style.
`timescale 1ns/1ps

module i2c_temp_sensor_responder #(
    parameter logic [6:0] SlaveAddress = 7'h48,
    parameter int         SyncStages   = 2
) (
    input  logic        clock,
    input  logic        Reset,
    input  logic        SCL,
    input  logic        SDAin,
    input  logic [15:0] Temperature,
    output logic        SDAdrive,
    output logic        Busy,
    output logic        ReadDone,
    output logic [2:0]  State
);

    typedef enum logic [2:0] {
        Idle    = 3'd0,
        Addr    = 3'd1,
        AckAddr = 3'd2,
        SendMsb = 3'd3,
        AckMsb  = 3'd4,
        SendLsb = 3'd5,
        AckLsb  = 3'd6,
        Ignore  = 3'd7
    } stateT;

    stateT                 stateReg, stateNext;
    logic [SyncStages-1:0] sclSync, sdaSync;
    logic                  sclPrev, sdaPrev;
    logic                  sclNow, sdaNow;
    logic                  sclRise, sclFall, startSeen, stopSeen;
    logic [2:0]            bitCount, countNext;
    logic [15:0]           shiftReg, shiftNext;
    logic                  byteDone, byteDoneNext;
    logic                  driveNext, busyNext, doneNext;

    // SDA may only change while SCL is low, so an SDA edge with SCL high is a bus condition
    assign sclNow    = sclSync[SyncStages-1];
    assign sdaNow    = sdaSync[SyncStages-1];
    assign sclRise   = sclNow & ~sclPrev;
    assign sclFall   = ~sclNow & sclPrev;
    assign startSeen = sclNow & sdaPrev & ~sdaNow;
    assign stopSeen  = sclNow & ~sdaPrev & sdaNow;
    assign State     = stateReg;

    always_ff @(posedge clock) begin
        if (Reset) begin
            sclSync  <= '1;
            sdaSync  <= '1;
            sclPrev  <= 1'b1;
            sdaPrev  <= 1'b1;
            stateReg <= Idle;
            bitCount <= 3'd0;
            shiftReg <= 16'd0;
            byteDone <= 1'b0;
            SDAdrive <= 1'b0;
            Busy     <= 1'b0;
            ReadDone <= 1'b0;
        end else begin
            sclSync  <= {sclSync[SyncStages-2:0], SCL};
            sdaSync  <= {sdaSync[SyncStages-2:0], SDAin};
            sclPrev  <= sclNow;
            sdaPrev  <= sdaNow;
            stateReg <= stateNext;
            bitCount <= countNext;
            shiftReg <= shiftNext;
            byteDone <= byteDoneNext;
            SDAdrive <= driveNext;
            Busy     <= busyNext;
            ReadDone <= doneNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        countNext    = bitCount;
        shiftNext    = shiftReg;
        byteDoneNext = byteDone;
        driveNext    = SDAdrive;
        busyNext     = Busy;
        doneNext     = 1'b0;
        if (startSeen) begin
            stateNext    = Addr;
            countNext    = 3'd0;
            byteDoneNext = 1'b0;
            driveNext    = 1'b0;
            busyNext     = 1'b0;
        end else if (stopSeen) begin
            stateNext = Idle;
            driveNext = 1'b0;
            busyNext  = 1'b0;
        end else begin
            case (stateReg)
                Addr: begin
                    if (sclRise) begin
                        shiftNext = {shiftReg[14:0], sdaNow};
                        countNext = bitCount + 3'd1;
                        if (bitCount == 3'd7) byteDoneNext = 1'b1;
                    end else if (sclFall && byteDone) begin
                        byteDoneNext = 1'b0;
                        if (shiftReg[7:1] == SlaveAddress && shiftReg[0]) begin
                            stateNext = AckAddr;
                            driveNext = 1'b1;
                            busyNext  = 1'b1;
                            shiftNext = Temperature;
                        end else begin
                            stateNext = Ignore;
                            driveNext = 1'b0;
                        end
                    end
                end
                AckAddr: begin
                    if (sclFall) begin
                        stateNext = SendMsb;
                        driveNext = ~shiftReg[15];
                        shiftNext = {shiftReg[14:0], 1'b0};
                        countNext = 3'd0;
                    end
                end
                // bitCount tracks how many of the byte's bits have already been presented
                SendMsb, SendLsb: begin
                    if (sclFall) begin
                        if (bitCount == 3'd7) begin
                            stateNext = (stateReg == SendMsb) ? AckMsb : AckLsb;
                            driveNext = 1'b0;
                            countNext = 3'd0;
                        end else begin
                            driveNext = ~shiftReg[15];
                            shiftNext = {shiftReg[14:0], 1'b0};
                            countNext = bitCount + 3'd1;
                        end
                    end
                end
                AckMsb: begin
                    if (sclRise && sdaNow) begin
                        stateNext = Ignore;
                        busyNext  = 1'b0;
                    end else if (sclFall) begin
                        stateNext = SendLsb;
                        driveNext = ~shiftReg[15];
                        shiftNext = {shiftReg[14:0], 1'b0};
                        countNext = 3'd0;
                    end
                end
                AckLsb: begin
                    if (sclRise) begin
                        stateNext = Ignore;
                        busyNext  = 1'b0;
                        doneNext  = 1'b1;
                    end
                end
                default: begin
                    driveNext = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_temp_sensor_responder.sv
// Bench for i2c_temp_sensor_responder: a bus-level controller model issues reads and
// compares returned bytes, ACKs and status against values derived from the address/temperature.
`timescale 1ns/1ps

module tb_i2c_temp_sensor_responder;

    localparam int Half = 8;

    logic        clock = 1'b0;
    logic        Reset = 1'b1;
    logic        SCL = 1'b1;
    logic        sdaCtl = 1'b1;
    logic [15:0] Temperature = 16'd0;
    logic        SDAdrive, Busy, ReadDone;
    logic [2:0]  State;
    logic        sdaLine;

    int testCount = 0;
    int failCount = 0;
    int doneCycles = 0;
    int driveCycles = 0;
    int illegalDrive = 0;

    // Open-drain wired-AND of the controller and the responder
    assign sdaLine = sdaCtl & ~SDAdrive;

    i2c_temp_sensor_responder dut (
        .clock(clock),
        .Reset(Reset),
        .SCL(SCL),
        .SDAin(sdaLine),
        .Temperature(Temperature),
        .SDAdrive(SDAdrive),
        .Busy(Busy),
        .ReadDone(ReadDone),
        .State(State)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (ReadDone === 1'b1) doneCycles++;
        if (SDAdrive === 1'b1) begin
            driveCycles++;
            if (!(State inside {3'd2, 3'd3, 3'd5})) illegalDrive++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic busStart();
        sdaCtl = 1'b1;
        waitClocks(Half);
        SCL = 1'b1;
        waitClocks(Half);
        sdaCtl = 1'b0;
        waitClocks(Half);
        SCL = 1'b0;
    endtask

    task automatic busStop();
        sdaCtl = 1'b0;
        waitClocks(Half);
        SCL = 1'b1;
        waitClocks(Half);
        sdaCtl = 1'b1;
        waitClocks(Half);
    endtask

    task automatic writeBit(input logic b);
        sdaCtl = b;
        waitClocks(Half);
        SCL = 1'b1;
        waitClocks(Half);
        SCL = 1'b0;
    endtask

    task automatic readBit(output logic b, output logic drv);
        sdaCtl = 1'b1;
        waitClocks(Half);
        SCL = 1'b1;
        waitClocks(Half / 2);
        b   = sdaLine;
        drv = SDAdrive;
        waitClocks(Half - Half / 2);
        SCL = 1'b0;
    endtask

    task automatic readByte(output logic [7:0] value);
        logic b, drv;
        for (int i = 7; i >= 0; i--) begin
            readBit(b, drv);
            value[i] = b;
        end
    endtask

    task automatic writeByte(input logic [7:0] value);
        for (int i = 7; i >= 0; i--) writeBit(value[i]);
    endtask

    // One complete read attempt (START .. STOP) checked against the expected sensor behaviour
    task automatic applyStimulus(input logic [7:0] addrByte, input logic [15:0] temp, input logic ackMsb);
        logic       match, b, drv;
        logic [7:0] value;
        int         done0, drive0, expDone;
        match   = (addrByte[7:1] == 7'h48) && addrByte[0];
        done0   = doneCycles;
        drive0  = driveCycles;
        expDone = 0;
        Temperature = temp;
        busStart();
        checkOutput("startState", State, 1);
        checkOutput("startDrive", SDAdrive, 0);
        writeByte(addrByte);
        readBit(b, drv);
        checkOutput("addrAck", b, match ? 0 : 1);
        checkOutput("addrAckDrive", drv, match);
        Temperature = 16'($urandom);
        checkOutput("busyAfterAddr", Busy, match);
        if (match) begin
            readByte(value);
            checkOutput("msbByte", value, temp[15:8]);
            writeBit(!ackMsb);
            if (ackMsb) begin
                readByte(value);
                checkOutput("lsbByte", value, temp[7:0]);
                writeBit(1'b1);
                expDone = 1;
            end
            checkOutput("busyAfterRead", Busy, 0);
            checkOutput("stateAfterRead", State, 7);
            checkOutput("readDonePulses", doneCycles - done0, expDone);
        end else begin
            readByte(value);
            checkOutput("ignoredByte", value, 8'hFF);
            checkOutput("ignoreState", State, 7);
            checkOutput("ignoreBusy", Busy, 0);
            checkOutput("ignoreNoDrive", driveCycles - drive0, 0);
            checkOutput("ignoreNoDone", doneCycles - done0, 0);
        end
        busStop();
        checkOutput("stopState", State, 0);
        checkOutput("stopBusy", Busy, 0);
    endtask

    initial begin
        logic       b, drv;
        logic [7:0] value;
        logic [7:0] addrByte;
        int         r;

        $display("[TB] start");
        Reset = 1'b1;
        waitClocks(2);
        checkOutput("resetState", State, 0);
        checkOutput("resetDrive", SDAdrive, 0);
        checkOutput("resetBusy", Busy, 0);
        checkOutput("resetDone", ReadDone, 0);
        Reset = 1'b0;
        waitClocks(4);

        applyStimulus(8'h91, 16'h1A30, 1'b1);
        applyStimulus(8'h93, 16'h5A5A, 1'b1);
        applyStimulus(8'h90, 16'hC3C3, 1'b1);
        applyStimulus(8'h91, 16'h8421, 1'b0);

        // Repeated START while the MSB is partly sent, followed by a fresh read
        Temperature = 16'h1A30;
        busStart();
        writeByte(8'h91);
        readBit(b, drv);
        checkOutput("abortAddrAck", b, 0);
        for (int i = 0; i < 3; i++) begin
            readBit(b, drv);
            checkOutput("abortMsbBit", b, 0);
        end
        applyStimulus(8'h91, 16'h00FF, 1'b1);

        // Reset in the middle of the LSB while a 0 bit is being driven
        Temperature = 16'h1A30;
        busStart();
        writeByte(8'h91);
        readBit(b, drv);
        readByte(value);
        checkOutput("preResetMsb", value, 8'h1A);
        writeBit(1'b0);
        for (int i = 0; i < 4; i++) readBit(b, drv);
        waitClocks(Half / 2);
        checkOutput("preResetDrive", SDAdrive, 1);
        Reset = 1'b1;
        waitClocks(1);
        checkOutput("midResetState", State, 0);
        checkOutput("midResetDrive", SDAdrive, 0);
        Reset = 1'b0;
        SCL = 1'b1;
        sdaCtl = 1'b1;
        waitClocks(Half);
        checkOutput("postResetState", State, 0);

        for (int n = 0; n < 24; n++) begin
            r = int'($urandom_range(0, 3));
            addrByte = (r == 0) ? 8'($urandom) : ((r == 1) ? 8'h90 : 8'h91);
            applyStimulus(addrByte, 16'($urandom), ($urandom_range(0, 3) != 0));
        end

        checkOutput("illegalDrive", illegalDrive, 0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
